// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the PucCPU fetch path: fetches over a req/ack
// handshake, executes control-flow opcodes and drives the return stack.
module pc_sequencer #(
  parameter int                          PC_WIDTH     = 8,
  parameter int                          OPCODE_WIDTH = 4,
  parameter int                          STACK_DEPTH  = 16,
  parameter logic [PC_WIDTH-1:0]         RESET_VECTOR = '0,
  parameter logic [OPCODE_WIDTH-1:0]     OP_NOP       = OPCODE_WIDTH'(0),
  parameter logic [OPCODE_WIDTH-1:0]     OP_CALL      = OPCODE_WIDTH'(1),
  parameter logic [OPCODE_WIDTH-1:0]     OP_RET       = OPCODE_WIDTH'(2),
  parameter logic [OPCODE_WIDTH-1:0]     OP_RESET     = OPCODE_WIDTH'(3),
  parameter logic [OPCODE_WIDTH-1:0]     OP_JMP       = OPCODE_WIDTH'(4),
  parameter logic [OPCODE_WIDTH-1:0]     OP_HALT      = OPCODE_WIDTH'(5),
  localparam int                         DW           = $clog2(STACK_DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    fetch_req,
  input  logic                    fetch_ack,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [PC_WIDTH-1:0]     operand,
  output logic [PC_WIDTH-1:0]     pc,
  output logic [OPCODE_WIDTH-1:0] stack_code,
  output logic [PC_WIDTH-1:0]     called_from,
  input  logic [PC_WIDTH-1:0]     return_to,
  output logic [DW-1:0]           depth,
  output logic                    halted,
  output logic                    overflow,
  output logic                    underflow
);

  localparam logic [DW-1:0] DEPTH_FULL = DW'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_INIT,
    S_FETCH,
    S_EXECUTE,
    S_HALT
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [PC_WIDTH-1:0]       r_pc;
  logic [PC_WIDTH-1:0]       w_pc_next;
  logic [OPCODE_WIDTH-1:0]   r_opcode;
  logic [PC_WIDTH-1:0]       r_operand;
  logic [DW-1:0]             r_depth;
  logic [DW-1:0]             w_depth_next;
  logic                      r_overflow;
  logic                      w_overflow_next;
  logic                      r_underflow;
  logic                      w_underflow_next;
  logic [OPCODE_WIDTH-1:0]   w_stack_code;
  logic                      w_fetch_req;
  logic                      w_accept;

  assign w_accept = w_fetch_req & fetch_ack;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_pc        <= RESET_VECTOR;
      r_opcode    <= OP_NOP;
      r_operand   <= '0;
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_depth     <= w_depth_next;
      r_overflow  <= w_overflow_next;
      r_underflow <= w_underflow_next;
      if (w_accept) begin
        r_opcode  <= opcode;
        r_operand <= operand;
      end
    end
  end

  // Stack opcode and depth change together in EXECUTE so the stack offset
  // and r_depth can never disagree; traps issue NOP so the stack is untouched.
  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_depth_next     = r_depth;
    w_overflow_next  = r_overflow;
    w_underflow_next = r_underflow;
    w_stack_code     = OP_NOP;
    w_fetch_req      = 1'b0;

    case (r_state)
      S_INIT: begin
        w_stack_code = OP_RESET;
        w_state_next = S_FETCH;
      end

      S_FETCH: begin
        w_fetch_req = 1'b1;
        if (fetch_ack) begin
          w_state_next = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        w_state_next = S_FETCH;
        if (r_opcode == OP_CALL) begin
          if (r_depth == DEPTH_FULL) begin
            w_overflow_next = 1'b1;
            w_state_next    = S_HALT;
          end else begin
            w_stack_code = OP_CALL;
            w_pc_next    = r_operand;
            w_depth_next = r_depth + DW'(1);
          end
        end else if (r_opcode == OP_RET) begin
          if (r_depth == '0) begin
            w_underflow_next = 1'b1;
            w_state_next     = S_HALT;
          end else begin
            w_stack_code = OP_RET;
            w_pc_next    = return_to;
            w_depth_next = r_depth - DW'(1);
          end
        end else if (r_opcode == OP_JMP) begin
          w_pc_next = r_operand;
        end else if (r_opcode == OP_RESET) begin
          w_stack_code = OP_RESET;
          w_pc_next    = RESET_VECTOR;
          w_depth_next = '0;
        end else if (r_opcode == OP_HALT) begin
          w_state_next = S_HALT;
        end else begin
          w_pc_next = r_pc + PC_WIDTH'(1);
        end
      end

      S_HALT: begin
        w_state_next = S_HALT;
      end

      default: begin
        w_state_next = S_INIT;
      end
    endcase
  end

  assign fetch_req   = w_fetch_req;
  assign pc          = r_pc;
  assign called_from = r_pc;
  assign stack_code  = w_stack_code;
  assign depth       = r_depth;
  assign halted      = (r_state == S_HALT);
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected fetch/stack/halt
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_pc_sequencer;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_CALL  = 4'h1;
  localparam logic [3:0] OP_RET   = 4'h2;
  localparam logic [3:0] OP_RESET = 4'h3;
  localparam logic [3:0] OP_JMP   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  logic       clk;
  logic       reset;
  logic       fetch_req;
  logic       fetch_ack;
  logic [3:0] opcode;
  logic [7:0] operand;
  logic [7:0] pc;
  logic [3:0] stack_code;
  logic [7:0] called_from;
  logic [7:0] return_to;
  logic [4:0] depth;
  logic       halted;
  logic       overflow;
  logic       underflow;

  pc_sequencer #(
    .PC_WIDTH(8), .OPCODE_WIDTH(4), .STACK_DEPTH(16), .RESET_VECTOR(8'h00),
    .OP_NOP(OP_NOP), .OP_CALL(OP_CALL), .OP_RET(OP_RET),
    .OP_RESET(OP_RESET), .OP_JMP(OP_JMP), .OP_HALT(OP_HALT)
  ) dut (
    .clock(clk), .reset(reset), .fetch_req(fetch_req), .fetch_ack(fetch_ack),
    .opcode(opcode), .operand(operand), .pc(pc), .stack_code(stack_code),
    .called_from(called_from), .return_to(return_to), .depth(depth),
    .halted(halted), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural return stack: stores called_from+1 on CALL.
  logic [7:0] rs_mem [0:15];
  int         rs_ptr;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_ptr <= 0;
    end else if (stack_code == OP_CALL && rs_ptr < 16) begin
      rs_mem[rs_ptr] <= called_from + 8'd1;
      rs_ptr         <= rs_ptr + 1;
    end else if (stack_code == OP_RET && rs_ptr > 0) begin
      rs_ptr <= rs_ptr - 1;
    end else if (stack_code == OP_RESET) begin
      rs_ptr <= 0;
    end
  end
  always_comb begin
    return_to = 8'hEE;
    if (rs_ptr > 0) return_to = rs_mem[rs_ptr-1];
  end

  typedef enum {EV_FETCH, EV_STACK, EV_HALT} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] pc;
    logic [4:0] depth;
    logic [3:0] code;
    int         len;
    logic       ovf;
    logic       unf;
  } ev_t;

  ev_t        exp_q[$];
  int         vectors;
  int         miscompares;

  logic [7:0] m_pc;
  logic [4:0] m_depth;
  logic       m_ovf;
  logic       m_unf;
  logic [7:0] m_stack[$];

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic void push_ev(input ev_kind_t k, input logic [3:0] code, input int len);
    ev_t e;
    e.kind  = k;
    e.pc    = m_pc;
    e.depth = m_depth;
    e.code  = code;
    e.len   = len;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    exp_q.push_back(e);
  endfunction

  // Monitor: one pop per DUT-visible event.
  int         fetch_len;
  logic       prev_halted;
  logic [7:0] halt_pc;
  logic [4:0] halt_depth;

  task automatic take(input ev_kind_t k, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '{kind: EV_FETCH, pc: 8'h0, depth: 5'h0, code: 4'h0, len: 0, ovf: 1'b0, unf: 1'b0};
    if (exp_q.size() == 0) begin
      chk("unexpected_event_kind", int'(k), -1);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", int'(k), int'(e.kind));
      ok = (e.kind == k);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    if (reset) begin
      chk("rst_pc", pc, 8'h00);
      chk("rst_fetch_req", fetch_req, 0);
      chk("rst_stack_code", stack_code, OP_RESET);
      chk("rst_depth", depth, 0);
      chk("rst_halted", halted, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_underflow", underflow, 0);
      fetch_len   = 0;
      prev_halted = 1'b0;
    end else begin
      if (halted && prev_halted) begin
        chk("halt_pc_frozen", pc, halt_pc);
        chk("halt_depth_frozen", depth, halt_depth);
        chk("halt_fetch_req", fetch_req, 0);
        chk("halt_stack_code", stack_code, OP_NOP);
      end
      if (fetch_req) fetch_len++;
      if (fetch_req && fetch_ack) begin
        take(EV_FETCH, e, ok);
        if (ok) begin
          chk("fetch_pc", pc, e.pc);
          chk("fetch_depth", depth, e.depth);
          chk("fetch_req_cycles", fetch_len, e.len);
          $display("fetch  pc=%02h depth=%0d req_cycles=%0d", pc, depth, fetch_len);
        end
        fetch_len = 0;
      end
      if (stack_code != OP_NOP) begin
        take(EV_STACK, e, ok);
        if (ok) begin
          chk("stack_code", stack_code, e.code);
          chk("called_from", called_from, e.pc);
          chk("stack_depth", depth, e.depth);
          $display("stack  code=%0h called_from=%02h depth=%0d", stack_code, called_from, depth);
        end
      end
      if (halted && !prev_halted) begin
        take(EV_HALT, e, ok);
        if (ok) begin
          chk("halt_pc", pc, e.pc);
          chk("halt_depth", depth, e.depth);
          chk("halt_overflow", overflow, e.ovf);
          chk("halt_underflow", underflow, e.unf);
          halt_pc    = e.pc;
          halt_depth = e.depth;
          $display("halt   pc=%02h depth=%0d ovf=%b unf=%b", pc, depth, overflow, underflow);
        end
      end
      prev_halted = halted;
    end
  end

  // Stimulus; called and returning at posedge+1.
  task automatic do_reset();
    reset     = 1'b1;
    fetch_ack = 1'b0;
    m_pc      = 8'h00;
    m_depth   = 5'd0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
    m_stack.delete();
    repeat (2) @(posedge clk);
    #1;
    push_ev(EV_STACK, OP_RESET, 0);
    reset = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] opd,
                       input int waits, input bit no_exec);
    int n;
    int w;
    bit ok;
    n  = 0;
    w  = 0;
    ok = 1'b0;
    push_ev(EV_FETCH, OP_NOP, waits + 1);
    while (n < 60) begin
      if (fetch_req) begin
        if (w == waits) begin
          ok = 1'b1;
          break;
        end
        w++;
      end
      n++;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      chk("fetch_req_timeout", fetch_req, 1);
      return;
    end
    fetch_ack = 1'b1;
    opcode    = op;
    operand   = opd;
    if (!no_exec) begin
      if (op == OP_CALL) begin
        if (m_depth < 5'd16) begin
          push_ev(EV_STACK, OP_CALL, 0);
          m_stack.push_back(m_pc + 8'd1);
          m_pc    = opd;
          m_depth = m_depth + 5'd1;
        end else begin
          m_ovf = 1'b1;
          push_ev(EV_HALT, OP_NOP, 0);
        end
      end else if (op == OP_RET) begin
        if (m_depth > 5'd0) begin
          push_ev(EV_STACK, OP_RET, 0);
          m_pc    = m_stack.pop_back();
          m_depth = m_depth - 5'd1;
        end else begin
          m_unf = 1'b1;
          push_ev(EV_HALT, OP_NOP, 0);
        end
      end else if (op == OP_JMP) begin
        m_pc = opd;
      end else if (op == OP_RESET) begin
        push_ev(EV_STACK, OP_RESET, 0);
        m_pc    = 8'h00;
        m_depth = 5'd0;
        m_stack.delete();
      end else if (op == OP_HALT) begin
        push_ev(EV_HALT, OP_NOP, 0);
      end else begin
        m_pc = m_pc + 8'd1;
      end
    end
    @(posedge clk);
    #1;
    fetch_ack = 1'b0;
    opcode    = OP_JMP;
    operand   = 8'hA5;
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    fetch_len   = 0;
    prev_halted = 1'b0;
    halt_pc     = 8'h00;
    halt_depth  = 5'd0;
    opcode      = OP_JMP;
    operand     = 8'hA5;
    fetch_ack   = 1'b0;
    reset       = 1'b1;

    // NOP at 0, then walk to 0x05; CALL 0x40 and RET back to 0x06.
    do_reset();
    for (int i = 0; i < 5; i++) issue(OP_NOP, 8'h00, 0, 1'b0);
    issue(OP_CALL, 8'h40, 0, 1'b0);
    issue(OP_RET, 8'h00, 0, 1'b0);

    // PC wrap at 0xFF, then JMP with three wait cycles.
    issue(OP_JMP, 8'hFF, 0, 1'b0);
    issue(OP_NOP, 8'h00, 0, 1'b0);
    issue(OP_JMP, 8'h10, 3, 1'b0);

    // Sixteen nested calls fill the stack; the seventeenth traps.
    for (int i = 0; i < 16; i++) issue(OP_CALL, 8'h20 + 8'(i), 0, 1'b0);
    issue(OP_CALL, 8'h80, 0, 1'b0);
    // Acks while halted must be ignored.
    fetch_ack = 1'b1;
    opcode    = OP_JMP;
    operand   = 8'h33;
    repeat (4) @(posedge clk);
    #1;
    fetch_ack = 1'b0;

    // RET straight after reset underflows.
    do_reset();
    issue(OP_RET, 8'h00, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Reset during EXECUTE of a CALL at depth 2.
    do_reset();
    issue(OP_CALL, 8'h30, 0, 1'b0);
    issue(OP_CALL, 8'h50, 0, 1'b0);
    issue(OP_CALL, 8'h70, 0, 1'b1);
    do_reset();
    issue(OP_NOP, 8'h00, 0, 1'b0);

    // RESET opcode from depth 1, then HALT opcode.
    issue(OP_CALL, 8'h30, 0, 1'b0);
    issue(OP_RESET, 8'h00, 0, 1'b0);
    issue(OP_HALT, 8'h00, 0, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("pending_events", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the PucCPU fetch path and the controlling end of the return-stack interface. It fetches instructions over a request/acknowledge handshake and decodes control-flow opcodes. It drives the stack's opcode and `called_from` inputs, consumes `return_to`, and keeps its own call-depth count so that stack overflow and underflow are trapped instead of wrapping silently.

## Interface
- `PC_WIDTH`, 8: program-counter and address width; must match the return stack.
- `OPCODE_WIDTH`, 4: opcode width; encodings `CALL`, `RET`, `RESET`, `JMP`, `HALT`, `NOP` come from `parameters.h`.
- `STACK_DEPTH`, 16: return-stack entries; the depth counter is `$clog2(STACK_DEPTH)+1` bits wide.
- `RESET_VECTOR`, 0: PC loaded on reset and on the `RESET` opcode.
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fetch_req`  out  1  high while requesting the instruction at `pc`.
- `fetch_ack`  in  1  instruction memory presents `opcode`/`operand` this cycle.
- `opcode`  in  OPCODE_WIDTH  fetched opcode; sampled only when `fetch_req & fetch_ack`.
- `operand`  in  PC_WIDTH  target address for `JMP`/`CALL`; sampled with `opcode`.
- `pc`  out  PC_WIDTH  current program counter.
- `stack_code`  out  OPCODE_WIDTH  opcode driven to the return stack's `reset_code` input.
- `called_from`  out  PC_WIDTH  address of the executing `CALL`; the stack stores `called_from + 1`.
- `return_to`  in  PC_WIDTH  top-of-stack address from the return stack, combinational.
- `depth`  out  $clog2(STACK_DEPTH)+1  live return-stack entries.
- `halted`  out  1  sequencer stopped; only `reset` leaves this state.
- `overflow`  out  1  sticky; a `CALL` was attempted at full depth.
- `underflow`  out  1  sticky; a `RET` was attempted at depth 0.

## Operation
- States are INIT, FETCH, EXECUTE and HALT.
- INIT
  - Entered while `reset` is high and held for one cycle after release.
  - Drives `stack_code = RESET` so the stack offset clears, then moves to FETCH.
- FETCH
  - `fetch_req = 1` with `pc` stable.
  - On `fetch_ack`, register `opcode` and `operand` and move to EXECUTE.
  - Without `fetch_ack`, wait indefinitely.
- EXECUTE lasts one cycle and applies the registered opcode:
  - `CALL`, `depth < STACK_DEPTH`: `stack_code = CALL`, `called_from = pc`, `pc <= operand`, `depth <= depth+1`.
  - `CALL`, `depth == STACK_DEPTH`: `stack_code = NOP`, set `overflow`, go to HALT; `pc` is unchanged.
  - `RET`, `depth > 0`: `stack_code = RET`, `pc <= return_to` sampled this cycle (before the stack decrements), `depth <= depth-1`.
  - `RET`, `depth == 0`: `stack_code = NOP`, set `underflow`, go to HALT.
  - `JMP`: `pc <= operand`.
  - `RESET`: `stack_code = RESET`, `pc <= RESET_VECTOR`, `depth <= 0`; the sticky flags are kept.
  - `HALT`: go to HALT; `pc` is unchanged.
  - Any other code: `pc <= pc + 1`, modulo 2^PC_WIDTH (0xFF wraps to 0x00).
  - Non-halting opcodes return to FETCH.
- `stack_code` is `NOP` in every cycle other than INIT and the EXECUTE cases listed above.
- `called_from` equals `pc` at all times; it only matters when `stack_code = CALL`.
- HALT: `fetch_req = 0`, `stack_code = NOP`, all outputs frozen.

## Timing
- Reset values: `pc = RESET_VECTOR`, `fetch_req = 0`, `stack_code = RESET`, `depth = 0`, `halted = 0`, `overflow = 0`, `underflow = 0`.
- Reset asserted mid-FETCH or mid-EXECUTE aborts the instruction immediately; no stack opcode is issued other than `RESET`.
- Minimum instruction time is 2 cycles: FETCH with `fetch_ack` in the same cycle, then EXECUTE. Each wait cycle adds one.
- `fetch_ack` is ignored whenever `fetch_req = 0`.
- `pc` updates on the clock edge that ends EXECUTE. The next FETCH presents the new `pc`.
- `halted`, `overflow` and `underflow` become high on the edge that ends the offending EXECUTE.
- `depth` changes on the same edge as the stack offset, so the two always agree.

## Test plan
- Reset, then `NOP` at address 0 with immediate ack -> `stack_code = RESET` for the first cycle; `pc` reads 0 then 1; `depth` stays 0.
- `CALL 0x40` at `pc = 0x05`, then `RET` at `0x40` -> `stack_code = CALL` with `called_from = 0x05`; `pc = 0x40`; `depth = 1`; after `RET`, `pc = 0x06` and `depth = 0`.
- 16 nested `CALL`s, then a 17th -> `depth = 16`; the 17th gives `overflow = 1`, `halted = 1`, `stack_code = NOP`, and `pc` holds at that `CALL`'s address.
- `RET` straight after reset -> `underflow = 1`, `halted = 1`; no `RET` reaches the stack.
- `NOP` at `pc = 0xFF`; `JMP 0x10` with `fetch_ack` delayed 3 cycles -> `pc` wraps to 0x00; `fetch_req` stays high for 4 cycles; `pc` becomes 0x10.
- `reset` pulsed during EXECUTE of `CALL` at `depth = 2` -> `depth = 0`, `pc = RESET_VECTOR`, `stack_code = RESET`; no `CALL` is issued.
